// File: rtl/ag32gbd_bram_arbiter.sv
// Single-port BRAM sequencer shared by register shadow writes,
// pixel writes and front-buffer reads, with A/B ping-pong control.
module ag32gbd_bram_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic       sys_clock,
  input  logic       sys_reset,
  input  logic       reg_wr_req,
  input  logic [7:0] reg_wr_offset,
  input  logic [7:0] reg_wr_data,
  output logic       reg_wr_done,
  input  logic       buf_wr_req,
  input  logic [7:0] buf_wr_offset,
  input  logic [7:0] buf_wr_data,
  output logic       buf_wr_done,
  input  logic       buf_rd_req,
  input  logic [7:0] buf_rd_offset,
  output logic [7:0] buf_rd_data,
  output logic       buf_rd_valid,
  input  logic       rd_frame_active,
  input  logic       flip_req,
  output logic       front_sel,
  output logic       flip_pending,
  output logic       bram_en,
  output logic       bram_we,
  output logic [9:0] bram_addr,
  output logic [7:0] bram_wdata,
  input  logic [7:0] bram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } state_t;

  typedef enum logic [1:0] {
    G_REG,
    G_WR,
    G_RD
  } gnt_t;

  localparam logic [2:0] LAT  = 3'(RD_LATENCY);
  localparam logic [2:0] LAT1 = 3'(RD_LATENCY + 1);

  state_t     state_q, state_d;
  gnt_t       gnt_q, gnt_d;
  logic       rr_q, rr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       front_sel_q, front_sel_d;
  logic       flip_pending_q, flip_pending_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       reg_done_q, reg_done_d;
  logic       wr_done_q, wr_done_d;
  logic       en_q, en_d;
  logic       we_q, we_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    front_sel_d    = front_sel_q;
    flip_pending_d = flip_pending_q | flip_req;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    reg_done_d     = 1'b0;
    wr_done_d      = 1'b0;
    en_d           = 1'b0;
    we_d           = 1'b0;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    case (state_q)
      IDLE: begin
        if (flip_pending_q && !rd_frame_active) begin
          front_sel_d    = ~front_sel_q;
          flip_pending_d = flip_req;
        end else if (reg_wr_req) begin
          gnt_d      = G_REG;
          addr_d     = {2'b10, reg_wr_offset};
          wdata_d    = reg_wr_data;
          en_d       = 1'b1;
          we_d       = 1'b1;
          reg_done_d = 1'b1;
          state_d    = ACCESS;
        end else if (buf_rd_req && (!buf_wr_req || !rr_q)) begin
          gnt_d   = G_RD;
          addr_d  = {1'b0, front_sel_q, buf_rd_offset};
          en_d    = 1'b1;
          rr_d    = 1'b1;
          state_d = ACCESS;
        end else if (buf_wr_req) begin
          // back buffer is the one not currently in front
          gnt_d     = G_WR;
          addr_d    = {1'b0, ~front_sel_q, buf_wr_offset};
          wdata_d   = buf_wr_data;
          en_d      = 1'b1;
          we_d      = 1'b1;
          wr_done_d = 1'b1;
          rr_d      = 1'b0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_q == G_RD) begin
          state_d = RD_WAIT;
          cnt_d   = 3'd2;
          if (RD_LATENCY == 1) begin
            rd_data_d  = bram_rdata;
            rd_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // cnt_q counts cycles since the enable cycle
        if (cnt_q == LAT1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAT) begin
            rd_data_d  = bram_rdata;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state_q        <= IDLE;
      gnt_q          <= G_REG;
      rr_q           <= 1'b0;
      cnt_q          <= 3'd0;
      front_sel_q    <= 1'b0;
      flip_pending_q <= 1'b0;
      rd_data_q      <= 8'h00;
      rd_valid_q     <= 1'b0;
      reg_done_q     <= 1'b0;
      wr_done_q      <= 1'b0;
      en_q           <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 10'h000;
      wdata_q        <= 8'h00;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      front_sel_q    <= front_sel_d;
      flip_pending_q <= flip_pending_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      reg_done_q     <= reg_done_d;
      wr_done_q      <= wr_done_d;
      en_q           <= en_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
    end
  end

  assign reg_wr_done  = reg_done_q;
  assign buf_wr_done  = wr_done_q;
  assign buf_rd_data  = rd_data_q;
  assign buf_rd_valid = rd_valid_q;
  assign front_sel    = front_sel_q;
  assign flip_pending = flip_pending_q;
  assign bram_en      = en_q;
  assign bram_we      = we_q;
  assign bram_addr    = addr_q;
  assign bram_wdata   = wdata_q;

endmodule

// File: tb/tb_ag32gbd_bram_arbiter.sv
// Directed bench for ag32gbd_bram_arbiter: latency, arbitration,
// buffer flip gating and reset behaviour (latency 1 and 2 instances).
module tb_ag32gbd_bram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_wr_req;
  logic [7:0] reg_wr_offset, reg_wr_data;
  logic       buf_wr_req;
  logic [7:0] buf_wr_offset, buf_wr_data;
  logic       buf_rd_req;
  logic [7:0] buf_rd_offset;
  logic       rd_frame_active, flip_req;

  logic       reg_wr_done, buf_wr_done, buf_rd_valid;
  logic [7:0] buf_rd_data;
  logic       front_sel, flip_pending, bram_en, bram_we;
  logic [9:0] bram_addr;
  logic [7:0] bram_wdata, bram_rdata;

  logic       reg_wr_done_b, buf_wr_done_b, buf_rd_valid_b;
  logic [7:0] buf_rd_data_b;
  logic       front_sel_b, flip_pending_b, bram_en_b, bram_we_b;
  logic [9:0] bram_addr_b;
  logic [7:0] bram_wdata_b, bram_rdata_b;

  logic [7:0] mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // BRAM model: writes from the latency-1 instance or the preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
  end

  assign bram_rdata = mem[bram_addr];

  always @(posedge clk) bram_rdata_b <= mem[bram_addr_b];

  ag32gbd_bram_arbiter #(.RD_LATENCY(1)) u_dut (
    .sys_clock(clk), .sys_reset(rst),
    .reg_wr_req(reg_wr_req), .reg_wr_offset(reg_wr_offset),
    .reg_wr_data(reg_wr_data), .reg_wr_done(reg_wr_done),
    .buf_wr_req(buf_wr_req), .buf_wr_offset(buf_wr_offset),
    .buf_wr_data(buf_wr_data), .buf_wr_done(buf_wr_done),
    .buf_rd_req(buf_rd_req), .buf_rd_offset(buf_rd_offset),
    .buf_rd_data(buf_rd_data), .buf_rd_valid(buf_rd_valid),
    .rd_frame_active(rd_frame_active), .flip_req(flip_req),
    .front_sel(front_sel), .flip_pending(flip_pending),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  ag32gbd_bram_arbiter #(.RD_LATENCY(2)) u_dut_b (
    .sys_clock(clk), .sys_reset(rst),
    .reg_wr_req(reg_wr_req), .reg_wr_offset(reg_wr_offset),
    .reg_wr_data(reg_wr_data), .reg_wr_done(reg_wr_done_b),
    .buf_wr_req(buf_wr_req), .buf_wr_offset(buf_wr_offset),
    .buf_wr_data(buf_wr_data), .buf_wr_done(buf_wr_done_b),
    .buf_rd_req(buf_rd_req), .buf_rd_offset(buf_rd_offset),
    .buf_rd_data(buf_rd_data_b), .buf_rd_valid(buf_rd_valid_b),
    .rd_frame_active(rd_frame_active), .flip_req(flip_req),
    .front_sel(front_sel_b), .flip_pending(flip_pending_b),
    .bram_en(bram_en_b), .bram_we(bram_we_b),
    .bram_addr(bram_addr_b), .bram_wdata(bram_wdata_b),
    .bram_rdata(bram_rdata_b)
  );

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reg_wr_req = 0; reg_wr_offset = 0; reg_wr_data = 0;
    buf_wr_req = 0; buf_wr_offset = 0; buf_wr_data = 0;
    buf_rd_req = 0; buf_rd_offset = 0;
    rd_frame_active = 0; flip_req = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    preload(10'h005, 8'h77);
    preload(10'h0A0, 8'hC3);
    @(negedge clk);
    checks++;
    if ({front_sel, flip_pending, buf_rd_valid, reg_wr_done,
         buf_wr_done, bram_en, bram_we} !== 7'd0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 0000000",
               {front_sel, flip_pending, buf_rd_valid, reg_wr_done,
                buf_wr_done, bram_en, bram_we});
    end
    checks++;
    if ({bram_addr, bram_wdata, buf_rd_data} !== 26'd0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0",
               {bram_addr, bram_wdata, buf_rd_data});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bram_en, buf_rd_valid, front_sel} !== 3'b000) begin
      errs++;
      $display("FAIL idle_after_reset: got %b want 000",
               {bram_en, buf_rd_valid, front_sel});
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    buf_rd_offset = 8'h05;
    buf_rd_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_we, bram_addr, buf_rd_valid} !==
        {1'b1, 1'b0, 10'h005, 1'b0}) begin
      errs++;
      $display("FAIL rd_access: got en=%b we=%b addr=%h v=%b want 1 0 005 0",
               bram_en, bram_we, bram_addr, buf_rd_valid);
    end
    @(negedge clk);
    checks++;
    if ({buf_rd_valid, buf_rd_data, bram_en} !== {1'b1, 8'h77, 1'b0}) begin
      errs++;
      $display("FAIL rd_valid: got v=%b d=%h en=%b want 1 77 0",
               buf_rd_valid, buf_rd_data, bram_en);
    end
    buf_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({buf_rd_valid, buf_rd_data, bram_en} !== {1'b0, 8'h77, 1'b0}) begin
      errs++;
      $display("FAIL rd_hold: got v=%b d=%h en=%b want 0 77 0",
               buf_rd_valid, buf_rd_data, bram_en);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    buf_wr_offset = 8'h3C;
    buf_wr_data = 8'hA5;
    buf_wr_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_wdata, buf_wr_done} !==
        {1'b1, 1'b1, 10'h13C, 8'hA5, 1'b1}) begin
      errs++;
      $display("FAIL wr_access: got en=%b we=%b a=%h d=%h done=%b want 1 1 13c a5 1",
               bram_en, bram_we, bram_addr, bram_wdata, buf_wr_done);
    end
    buf_wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_we, buf_wr_done} !== 3'b000) begin
      errs++;
      $display("FAIL wr_after: got %b want 000",
               {bram_en, bram_we, buf_wr_done});
    end
  endtask

  task automatic test_arbitration();
    logic [10:0] exp_g [0:4];
    int ng;
    int ovl;
    exp_g[0] = {1'b1, 10'h212};
    exp_g[1] = {1'b0, 10'h005};
    exp_g[2] = {1'b1, 10'h13C};
    exp_g[3] = {1'b0, 10'h005};
    exp_g[4] = {1'b1, 10'h13C};
    ng = 0;
    ovl = 0;
    @(negedge clk);
    reg_wr_offset = 8'h12; reg_wr_data = 8'h34; reg_wr_req = 1'b1;
    buf_rd_offset = 8'h05; buf_rd_req = 1'b1;
    buf_wr_offset = 8'h3C; buf_wr_data = 8'h5A; buf_wr_req = 1'b1;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      if (int'(reg_wr_done) + int'(buf_wr_done) + int'(buf_rd_valid) > 1)
        ovl++;
      if (bram_en) begin
        checks++;
        if ({bram_we, bram_addr} !== exp_g[ng]) begin
          errs++;
          $display("FAIL arb_grant%0d: got %h want %h",
                   ng, {bram_we, bram_addr}, exp_g[ng]);
        end
        ng++;
      end
      if (reg_wr_done) reg_wr_req = 1'b0;
    end
    reg_wr_req = 1'b0; buf_rd_req = 1'b0; buf_wr_req = 1'b0;
    checks++;
    if (ng != 5) begin
      errs++;
      $display("FAIL arb_timeout: got %0d grants want 5", ng);
    end
    checks++;
    if (ovl != 0) begin
      errs++;
      $display("FAIL arb_overlap: got %0d overlaps want 0", ovl);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_flip_gating();
    @(negedge clk);
    rd_frame_active = 1'b1;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    checks++;
    if ({flip_pending, front_sel} !== 2'b10) begin
      errs++;
      $display("FAIL flip_blocked: got pend/front=%b want 10",
               {flip_pending, front_sel});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({flip_pending, front_sel} !== 2'b10) begin
      errs++;
      $display("FAIL flip_still_blocked: got %b want 10",
               {flip_pending, front_sel});
    end
    rd_frame_active = 1'b0;
    @(negedge clk);
    checks++;
    if ({flip_pending, front_sel} !== 2'b01) begin
      errs++;
      $display("FAIL flip_done: got pend/front=%b want 01",
               {flip_pending, front_sel});
    end
    buf_wr_offset = 8'h00;
    buf_wr_data = 8'h66;
    buf_wr_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_we, bram_addr, buf_wr_done} !== {1'b1, 10'h000, 1'b1}) begin
      errs++;
      $display("FAIL flip_wr_addr: got we=%b a=%h done=%b want 1 000 1",
               bram_we, bram_addr, buf_wr_done);
    end
    buf_wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_merged_flip();
    int toggles;
    logic prev;
    @(negedge clk);
    rd_frame_active = 1'b1;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (2) @(negedge clk);
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    checks++;
    if ({flip_pending, front_sel} !== 2'b11) begin
      errs++;
      $display("FAIL merge_blocked: got pend/front=%b want 11",
               {flip_pending, front_sel});
    end
    rd_frame_active = 1'b0;
    toggles = 0;
    prev = front_sel;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (front_sel !== prev) toggles++;
      prev = front_sel;
    end
    checks++;
    if (toggles != 1) begin
      errs++;
      $display("FAIL merge_toggles: got %0d want 1", toggles);
    end
    checks++;
    if ({flip_pending, front_sel} !== 2'b00) begin
      errs++;
      $display("FAIL merge_final: got pend/front=%b want 00",
               {flip_pending, front_sel});
    end
  endtask

  task automatic test_flip_same_cycle();
    @(negedge clk);
    rd_frame_active = 1'b1;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    @(negedge clk);
    rd_frame_active = 1'b0;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    checks++;
    if ({flip_pending, front_sel} !== 2'b11) begin
      errs++;
      $display("FAIL same_cycle_flip: got pend/front=%b want 11",
               {flip_pending, front_sel});
    end
    @(negedge clk);
    checks++;
    if ({flip_pending, front_sel} !== 2'b00) begin
      errs++;
      $display("FAIL second_flip: got pend/front=%b want 00",
               {flip_pending, front_sel});
    end
  endtask

  task automatic test_reset_mid_read();
    int nv;
    int lat;
    repeat (3) @(negedge clk);
    buf_rd_offset = 8'hA0;
    buf_rd_req = 1'b1;
    @(negedge clk);
    buf_rd_req = 1'b0;
    checks++;
    if ({bram_en_b, bram_addr_b} !== {1'b1, 10'h0A0}) begin
      errs++;
      $display("FAIL mid_rd_access: got en=%b a=%h want 1 0a0",
               bram_en_b, bram_addr_b);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({front_sel_b, flip_pending_b, buf_rd_valid_b, reg_wr_done_b,
         buf_wr_done_b, bram_en_b, bram_we_b} !== 7'd0) begin
      errs++;
      $display("FAIL mid_rst_flags: got %b want 0000000",
               {front_sel_b, flip_pending_b, buf_rd_valid_b,
                reg_wr_done_b, buf_wr_done_b, bram_en_b, bram_we_b});
    end
    checks++;
    if ({bram_addr_b, bram_wdata_b, buf_rd_data_b} !== 26'd0) begin
      errs++;
      $display("FAIL mid_rst_data: got %h want 0",
               {bram_addr_b, bram_wdata_b, buf_rd_data_b});
    end
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (buf_rd_valid_b) nv++;
    end
    checks++;
    if (nv != 0) begin
      errs++;
      $display("FAIL mid_rst_no_valid: got %0d pulses want 0", nv);
    end
    buf_rd_req = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (buf_rd_valid_b) lat = c;
    end
    buf_rd_req = 1'b0;
    checks++;
    if (lat != 3 || buf_rd_data_b !== 8'hC3) begin
      errs++;
      $display("FAIL post_rst_read: got lat=%0d d=%h want 3 c3",
               lat, buf_rd_data_b);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_single_write();
    test_arbitration();
    test_flip_gating();
    test_merged_flip();
    test_flip_same_cycle();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
